// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage registers.
// The stage's optional skid slot is selected with PIPE_STAGE_SKID_EN.
package pipe_pkg;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       zero;
        logic [1:0] spare;
    } ctrl_t;

    localparam int CTRL_W     = $bits(ctrl_t);
    localparam int DATA_W_DEF = 64;
    localparam int WA_W_DEF   = 5;

    localparam ctrl_t CTRL_BUBBLE = '0;

    // Number of occupied slots, given the valid bits of main and skid.
    function automatic logic [1:0] occupancy(input logic m_valid, input logic s_valid);
        return {1'b0, m_valid} + {1'b0, s_valid};
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline slot: valid + control + write address + payload register.
// clear_ctrl turns the slot into a bubble; wa and data keep their value.
module pipe_slot #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int WA_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear_ctrl,
    input  logic [CTRL_W-1:0] src_ctrl,
    input  logic [WA_W-1:0]   src_wa,
    input  logic [DATA_W-1:0] src_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [WA_W-1:0]   wa,
    output logic [DATA_W-1:0] data
);
    import pipe_pkg::*;

    logic              valid_reg;
    logic [CTRL_W-1:0] ctrl_reg;
    logic [WA_W-1:0]   wa_reg;
    logic [DATA_W-1:0] data_reg;

    // Clearing wins over loading so a flush always leaves a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= 1'b0;
            ctrl_reg  <= '0;
            wa_reg    <= '0;
            data_reg  <= '0;
        end else if (clear_ctrl) begin
            valid_reg <= 1'b0;
            ctrl_reg  <= CTRL_W'(CTRL_BUBBLE);
        end else if (load) begin
            valid_reg <= 1'b1;
            ctrl_reg  <= src_ctrl;
            wa_reg    <= src_wa;
            data_reg  <= src_data;
        end
    end

    assign valid = valid_reg;
    assign ctrl  = ctrl_reg;
    assign wa    = wa_reg;
    assign data  = data_reg;

endmodule

// File: rtl/pipe_stage.sv
// Pipeline stage register with valid/ready handshake, stall and flush.
// Define PIPE_STAGE_SKID_EN to add a skid slot and register in_ready.
module pipe_stage #(
    parameter int DATA_W = pipe_pkg::DATA_W_DEF,
    parameter int CTRL_W = pipe_pkg::CTRL_W,
    parameter int WA_W   = pipe_pkg::WA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [WA_W-1:0]   in_wa,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [WA_W-1:0]   out_wa,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        level
);
    import pipe_pkg::*;

    logic              m_valid;
    logic [CTRL_W-1:0] m_ctrl;
    logic [WA_W-1:0]   m_wa;
    logic [DATA_W-1:0] m_data;

    logic              xfer_in;
    logic              xfer_out;
    logic              load_m;
    logic              clear_m;
    logic [CTRL_W-1:0] m_src_ctrl;
    logic [WA_W-1:0]   m_src_wa;
    logic [DATA_W-1:0] m_src_data;

`ifdef PIPE_STAGE_SKID_EN
    logic              s_valid;
    logic [CTRL_W-1:0] s_ctrl;
    logic [WA_W-1:0]   s_wa;
    logic [DATA_W-1:0] s_data;
    logic              load_s;
    logic              clear_s;
    logic              s_valid_next;
    logic              m_free;
    logic              in_ready_reg;

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .WA_W   (WA_W)
    ) s_slot (
        .clk        (clk),
        .rst        (rst),
        .load       (load_s),
        .clear_ctrl (clear_s),
        .src_ctrl   (in_ctrl),
        .src_wa     (in_wa),
        .src_data   (in_data),
        .valid      (s_valid),
        .ctrl       (s_ctrl),
        .wa         (s_wa),
        .data       (s_data)
    );

    // S is only ever occupied while M is full, so S always feeds M first.
    always_comb begin
        m_free       = ~m_valid | out_ready;
        xfer_in      = in_valid & in_ready_reg;
        load_m       = ~flush & (s_valid ? out_ready : (xfer_in & m_free));
        load_s       = ~flush & ~s_valid & xfer_in & ~m_free;
        clear_s      = flush | (s_valid & out_ready);
        s_valid_next = ~flush & (load_s | (s_valid & ~out_ready));
        m_src_ctrl   = s_valid ? s_ctrl : in_ctrl;
        m_src_wa     = s_valid ? s_wa   : in_wa;
        m_src_data   = s_valid ? s_data : in_data;
    end

    // Tracks ~s_valid one edge ahead so in_ready comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_reg <= 1'b1;
        end else begin
            in_ready_reg <= ~s_valid_next;
        end
    end

    assign in_ready = in_ready_reg;
    assign level    = occupancy(m_valid, s_valid);
`else
    assign in_ready = ~m_valid | out_ready;

    always_comb begin
        xfer_in    = in_valid & in_ready;
        load_m     = xfer_in & ~flush;
        m_src_ctrl = in_ctrl;
        m_src_wa   = in_wa;
        m_src_data = in_data;
    end

    assign level = {1'b0, m_valid};
`endif

    // A simultaneous load keeps M full, giving one transfer per cycle.
    always_comb begin
        xfer_out = m_valid & out_ready;
        clear_m  = flush | (xfer_out & ~load_m);
    end

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W),
        .WA_W   (WA_W)
    ) m_slot (
        .clk        (clk),
        .rst        (rst),
        .load       (load_m),
        .clear_ctrl (clear_m),
        .src_ctrl   (m_src_ctrl),
        .src_wa     (m_src_wa),
        .src_data   (m_src_data),
        .valid      (m_valid),
        .ctrl       (m_ctrl),
        .wa         (m_wa),
        .data       (m_data)
    );

    assign out_valid = m_valid;
    assign out_ctrl  = m_valid ? m_ctrl : CTRL_W'(CTRL_BUBBLE);
    assign out_wa    = m_wa;
    assign out_data  = m_data;

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage: directed table, corner sequences and
// random traffic against a FIFO-based reference model (PIPE_STAGE_SKID_EN aware).
module tb_pipe_stage;

`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_ctrl = '0;
    logic [4:0]  in_wa = '0;
    logic [63:0] in_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_ctrl;
    logic [4:0]  out_wa;
    logic [63:0] out_data;
    logic [1:0]  level;

    always #5 clk = ~clk;

    pipe_stage dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_wa     (in_wa),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_wa    (out_wa),
        .out_data  (out_data),
        .level     (level)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: the stage is a FIFO of capacity 1 (or 2 with skid).
    typedef struct {
        logic [7:0]  c;
        logic [4:0]  wa;
        logic [63:0] d;
    } ent_t;

    ent_t        q[$];
    logic [63:0] sh_data = '0;
    logic [4:0]  sh_wa = '0;
    bit          model_ok = 1'b0;

    task automatic cycle(input logic r, input logic iv, input logic [7:0] c,
                         input logic [63:0] d, input logic ordy, input logic fl,
                         output logic irdy_seen);
        logic irdy_exp;
        ent_t e;
        @(negedge clk);
        rst = r; in_valid = iv; in_ctrl = c; in_wa = d[4:0]; in_data = d;
        out_ready = ordy; flush = fl;
        #1;
        irdy_exp = SKID ? (q.size() < 2) : (q.size() == 0 || ordy);
        irdy_seen = in_ready;
        if (model_ok) chk("in_ready", {63'd0, in_ready}, {63'd0, irdy_exp});
        @(posedge clk);
        if (r) begin
            q.delete();
            sh_data = '0;
            sh_wa = '0;
            model_ok = 1'b1;
        end else if (fl) begin
            q.delete();
        end else begin
            if (q.size() > 0 && ordy) void'(q.pop_front());
            if (iv && irdy_exp) begin
                e.c = c; e.wa = d[4:0]; e.d = d;
                q.push_back(e);
            end
        end
        if (q.size() > 0) begin
            sh_data = q[0].d;
            sh_wa = q[0].wa;
        end
        #1;
        if (model_ok) begin
            chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
            chk("out_ctrl", {56'd0, out_ctrl}, (q.size() > 0) ? {56'd0, q[0].c} : 64'd0);
            chk("out_data", out_data, sh_data);
            chk("out_wa", {59'd0, out_wa}, {59'd0, sh_wa});
            chk("level", {62'd0, level}, 64'(q.size()));
        end
    endtask

    typedef struct {
        logic        r;
        logic        iv;
        logic [7:0]  c;
        logic [63:0] d;
        logic        ordy;
        logic        fl;
        logic        e_valid;
        logic [7:0]  e_ctrl;
        logic [63:0] e_data;
        logic [1:0]  e_level;
        logic        e_irdy;
    } vec_t;

    vec_t vt[14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic irdy;

        // Directed table: reset with live input, streaming, flush.
        vt[0] = '{1'b1, 1'b1, 8'h1F, 64'hDEAD, 1'b1, 1'b0, 1'b0, 8'h00, 64'h0, 2'd0, 1'b1};
        for (int i = 1; i <= 8; i++)
            vt[i] = '{1'b0, 1'b1, 8'h01, 64'(i), 1'b1, 1'b0, 1'b1, 8'h01, 64'(i), 2'd1, 1'b1};
        vt[9]  = '{1'b0, 1'b1, 8'h1F, 64'hAB, 1'b1, 1'b0, 1'b1, 8'h1F, 64'hAB, 2'd1, 1'b1};
        vt[10] = '{1'b0, 1'b1, 8'h1F, 64'hCD, 1'b1, 1'b1, 1'b0, 8'h00, 64'hAB, 2'd0, 1'b1};
        vt[11] = '{1'b0, 1'b0, 8'h00, 64'h0,  1'b1, 1'b0, 1'b0, 8'h00, 64'hAB, 2'd0, 1'b1};
        vt[12] = '{1'b0, 1'b1, 8'h03, 64'h11, 1'b1, 1'b0, 1'b1, 8'h03, 64'h11, 2'd1, 1'b1};
        vt[13] = '{1'b0, 1'b0, 8'h00, 64'h0,  1'b1, 1'b0, 1'b0, 8'h00, 64'h11, 2'd0, 1'b1};

        cycle(1'b1, 1'b0, 8'h0, 64'h0, 1'b1, 1'b0, irdy);
        for (int i = 0; i < 14; i++) begin
            cycle(vt[i].r, vt[i].iv, vt[i].c, vt[i].d, vt[i].ordy, vt[i].fl, irdy);
            chk("tbl_in_ready", {63'd0, irdy}, {63'd0, vt[i].e_irdy});
            chk("tbl_out_valid", {63'd0, out_valid}, {63'd0, vt[i].e_valid});
            chk("tbl_out_ctrl", {56'd0, out_ctrl}, {56'd0, vt[i].e_ctrl});
            chk("tbl_out_data", out_data, vt[i].e_data);
            chk("tbl_level", {62'd0, level}, {62'd0, vt[i].e_level});
            $display("row %0d: valid=%0b ctrl=%0h data=%0h level=%0d", i, out_valid, out_ctrl, out_data, level);
        end

        // Stall with 0x55 held in M.
        cycle(1'b0, 1'b1, 8'h07, 64'h55, 1'b1, 1'b0, irdy);
`ifdef PIPE_STAGE_SKID_EN
        cycle(1'b0, 1'b1, 8'h09, 64'h66, 1'b0, 1'b0, irdy);
        chk("skid_accept", {63'd0, irdy}, 64'd1);
        chk("skid_level2", {62'd0, level}, 64'd2);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 8'h0A, 64'h99, 1'b0, 1'b0, irdy);
            chk("skid_full_in_ready", {63'd0, irdy}, 64'd0);
            chk("skid_stall_data", out_data, 64'h55);
            chk("skid_stall_ctrl", {56'd0, out_ctrl}, 64'h07);
        end
        cycle(1'b0, 1'b0, 8'h00, 64'h0, 1'b1, 1'b0, irdy);
        chk("skid_order_2nd", out_data, 64'h66);
        cycle(1'b0, 1'b0, 8'h00, 64'h0, 1'b1, 1'b0, irdy);
        chk("skid_drained", {63'd0, out_valid}, 64'd0);
`else
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 8'h09, 64'h66, 1'b0, 1'b0, irdy);
            chk("stall_in_ready", {63'd0, irdy}, 64'd0);
            chk("stall_data", out_data, 64'h55);
            chk("stall_ctrl", {56'd0, out_ctrl}, 64'h07);
        end
        cycle(1'b0, 1'b1, 8'h09, 64'h66, 1'b1, 1'b0, irdy);
        chk("resume_in_ready", {63'd0, irdy}, 64'd1);
        chk("resume_data", out_data, 64'h66);
        cycle(1'b0, 1'b0, 8'h00, 64'h0, 1'b1, 1'b0, irdy);
`endif
        $display("stall sequence done: level=%0d", level);

`ifdef PIPE_STAGE_SKID_EN
        // Flush while both slots are full.
        cycle(1'b0, 1'b1, 8'h1F, 64'h10, 1'b1, 1'b0, irdy);
        cycle(1'b0, 1'b1, 8'h1F, 64'h20, 1'b0, 1'b0, irdy);
        chk("pre_flush_level", {62'd0, level}, 64'd2);
        cycle(1'b0, 1'b0, 8'h00, 64'h0, 1'b0, 1'b1, irdy);
        chk("flush_full_level", {62'd0, level}, 64'd0);
        chk("flush_full_ctrl", {56'd0, out_ctrl}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 64'h0, 1'b1, 1'b0, irdy);
            chk("post_flush_in_ready", {63'd0, irdy}, 64'd1);
            chk("post_flush_no_stale", {63'd0, out_valid}, 64'd0);
        end
        $display("skid flush sequence done: level=%0d", level);
`endif

        // Reset pulse in the middle of a stall.
        cycle(1'b0, 1'b1, 8'h1F, 64'h44, 1'b1, 1'b0, irdy);
        cycle(1'b0, 1'b1, 8'h1F, 64'h45, 1'b0, 1'b0, irdy);
        cycle(1'b1, 1'b0, 8'h00, 64'h0, 1'b0, 1'b0, irdy);
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_data", out_data, 64'd0);
        chk("mid_rst_wa", {59'd0, out_wa}, 64'd0);
        chk("mid_rst_level", {62'd0, level}, 64'd0);
        cycle(1'b0, 1'b1, 8'h05, 64'h77, 1'b1, 1'b0, irdy);
        chk("after_rst_data", out_data, 64'h77);
        cycle(1'b0, 1'b0, 8'h00, 64'h0, 1'b1, 1'b0, irdy);
        chk("after_rst_alone", {63'd0, out_valid}, 64'd0);
        $display("mid-stall reset sequence done: level=%0d", level);

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 127) == 0,
                  $urandom_range(0, 3) != 0,
                  8'($urandom),
                  {32'($urandom), 32'($urandom)},
                  $urandom_range(0, 9) < 6,
                  $urandom_range(0, 31) == 0,
                  irdy);
        end
        $display("random phase done: 800 cycles");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage.md
# pipe_stage

Parametrised pipeline stage register with valid/ready handshake, stall back-pressure and flush. It replaces the fixed per-boundary latches (IF/ID, ID/EX, EX/MEM, MEM/WB) in the pipelined core. The control bundle and the data payload are carried separately, so a flush can turn a held instruction into a bubble without touching the datapath. An optional skid slot registers `in_ready` to break the combinational stall chain across stages.

## Interface
- `DATA_W`, 64: data payload width (ALU result, rd2, PC offset, etc., concatenated by the instantiating stage).
- `CTRL_W`, 8: control bundle width (regWrite, memToReg, branch, memRead, memWrite, zero, spare).
- `WA_W`, 5: write-address width.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  upstream holds a valid instruction.
- `in_ready`  out  1  stage accepts `in_*` this cycle.
- `in_ctrl`  in  CTRL_W  control bundle.
- `in_wa`  in  WA_W  destination register address.
- `in_data`  in  DATA_W  data payload.
- `flush`  in  1  kill all held and incoming entries (branch taken / exception).
- `out_valid`  out  1  output holds a valid instruction.
- `out_ready`  in  1  downstream accepts this cycle.
- `out_ctrl`  out  CTRL_W  registered control; forced to 0 whenever `out_valid`=0.
- `out_wa`  out  WA_W  registered write address.
- `out_data`  out  DATA_W  registered payload.
- `level`  out  2  number of held entries (0..1, or 0..2 with skid).

## Operation
- Transfer in: `in_valid & in_ready`. Transfer out: `out_valid & out_ready`.
- Main slot (M) drives `out_*`.
- `out_ctrl` is masked to 0 when M is empty, so downstream never sees write or memory strobes from a bubble.
- Base mode:
  - `in_ready = ~M.valid | out_ready` (combinational).
  - On transfer-in, M loads `in_*`.
  - On transfer-out without transfer-in, M.valid clears.
  - With both in the same cycle, M reloads (full throughput, no bubble).
- Stall: `out_ready`=0 with M full holds all `out_*` bit-stable.
- Flush (highest priority after `rst`):
  - Next cycle, all slots are invalid and control fields are cleared.
  - Data and wa fields retain their value.
  - An input presented in the flush cycle is dropped, even if `in_ready`=1.
  - `in_ready` is unaffected by `flush` in the same cycle.
- Reset: `out_valid`=0, `out_ctrl`=0, `out_wa`=0, `out_data`=0, `level`=0. Skid slot is cleared. `in_ready` is 1 in the first cycle after reset.
- Reset asserted mid-stall discards held entries; no partial state survives.

## Timing
- Latency: 1 cycle from transfer-in to `out_valid` in both modes.
- Throughput: 1 instruction per cycle under continuous `out_ready`=1.
- All outputs are registered except base-mode `in_ready`.
- `level` updates in the same cycle as `out_valid`.
- Flush asserted for N cycles yields `out_valid`=0 for N cycles starting one cycle later.

## Configuration
- `PIPE_STAGE_SKID_EN` defined:
  - Adds skid slot S. `in_ready` is a register, equal to `~S.valid` as of the previous edge.
  - If M is full, `out_ready`=0 and a transfer-in occurs, the entry goes to S.
  - When S is full and M drains, S moves to M in the same edge.
  - While S is full, `in_ready` is 0.
  - Ordering is strictly FIFO. `level` reaches 2.
- `PIPE_STAGE_SKID_EN` not defined:
  - Base mode only. No S storage. `level` never exceeds 1 and its MSB is tied to 0.

## Structure
- Shared package `pipe_pkg`:
  - `ctrl_t` packed struct (regWrite, memToReg, branch, memRead, memWrite, zero, 2 spare) and `CTRL_W` = `$bits(ctrl_t)`.
  - Default `DATA_W` and `WA_W` constants.
  - A `CTRL_BUBBLE` constant (all zero).
- Sub-module `pipe_slot`: a single valid + ctrl + wa + data register with `load`, `clear_ctrl` and `rst`. It is instantiated once for M and once more for S under the macro.
- Top-level handles handshake, priority and the output mask.

## Test plan
- Reset:
  - Stimulus: drive `in_*` = valid, ctrl 0x1F, data 0xDEAD while `rst`=1.
  - Required: after reset, `out_valid`=0, `out_ctrl`=0, `out_data`=0, `level`=0, `in_ready`=1.
- Streaming:
  - Stimulus: 8 back-to-back inputs, data 1..8, with `out_ready`=1.
  - Required: outputs 1..8 on consecutive cycles, each one cycle after its input, no bubbles.
- Stall:
  - Stimulus: hold data 0x55 in M with `out_ready`=0 for 4 cycles.
  - Required: `out_*` stable throughout.
  - Base mode: `in_ready`=0, and the next input is accepted on the cycle `out_ready` returns.
  - Skid mode: one extra input (0x66) is accepted into S, `level`=2, `in_ready` drops, and 0x55 then 0x66 emerge in order.
- Flush:
  - Stimulus: M holds ctrl 0x1F, data 0xAB; assert `flush` together with a valid input (0xCD).
  - Required: next cycle `out_valid`=0, `out_ctrl`=0, `level`=0, and 0xCD never appears.
- Flush under skid-full (macro on):
  - Stimulus: flush with `level`=2.
  - Required: `level`=0 next cycle, `in_ready`=1 the following cycle, no stale entry delivered.
- Mid-stall reset:
  - Stimulus: `rst` pulse while stalled with `level`>0.
  - Required: all outputs reach reset values the next cycle; a subsequent input of 0x77 emerges alone.
